// File: rtl/vedic_pkg.sv
// Shared constants and types for the sequential 8x8 multiplier built around an external 4x4 core.
package vedic_pkg;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned RES_W  = 2 * IN_W;
  localparam int unsigned NUM_PP = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } state_e;

  typedef logic [1:0] step_t;

  localparam step_t LAST_STEP = step_t'(NUM_PP - 1);

  // Partial-product shift per step, in units of LANE_W: lo*lo, hi*lo, lo*hi, hi*hi
  localparam int unsigned PP_SHIFT [NUM_PP] = '{0, 1, 1, 2};

endpackage

// File: rtl/vedic_pp_sel.sv
// Maps the current step and latched operands onto the 4x4 core lanes and the product shift.
module vedic_pp_sel #(
  parameter int unsigned IN_W    = vedic_pkg::IN_W,
  parameter int unsigned LANE_W  = vedic_pkg::LANE_W,
  parameter int unsigned SHIFT_W = $clog2(2 * LANE_W + 1)
) (
  input  logic                en,
  input  vedic_pkg::step_t    step,
  input  logic [IN_W-1:0]     a,
  input  logic [IN_W-1:0]     b,
  output logic [LANE_W-1:0]   mul_a,
  output logic [LANE_W-1:0]   mul_b,
  output logic [SHIFT_W-1:0]  shift
);
  import vedic_pkg::*;

  logic [LANE_W-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = a[LANE_W-1:0];
  assign a_hi = a[IN_W-1:LANE_W];
  assign b_lo = b[LANE_W-1:0];
  assign b_hi = b[IN_W-1:LANE_W];

  // Lanes are forced to zero outside MUL so the core sees a quiet bus.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    shift = '0;
    if (en) begin
      unique case (step)
        2'd0: begin mul_a = a_lo; mul_b = b_lo; end
        2'd1: begin mul_a = a_hi; mul_b = b_lo; end
        2'd2: begin mul_a = a_lo; mul_b = b_hi; end
        2'd3: begin mul_a = a_hi; mul_b = b_hi; end
      endcase
      shift = SHIFT_W'(PP_SHIFT[step] * LANE_W);
    end
  end

endmodule

// File: rtl/vedic_8x8_seq.sv
// Sequential 8x8 unsigned multiplier driving an external 4x4 core, one partial product per cycle.
// Optional running multiply-accumulate with sticky overflow when VEDIC_SEQ_MAC_EN is defined.
module vedic_8x8_seq #(
  parameter int unsigned IN_W   = vedic_pkg::IN_W,
  parameter int unsigned LANE_W = vedic_pkg::LANE_W,
  parameter int unsigned RES_W  = vedic_pkg::RES_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_a,
  input  logic [IN_W-1:0]       in_b,
  output logic [LANE_W-1:0]     mul_a,
  output logic [LANE_W-1:0]     mul_b,
  input  logic [2*LANE_W-1:0]   mul_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RES_W-1:0]      out_prod,
  output logic                  busy
`ifdef VEDIC_SEQ_MAC_EN
  ,
  input  logic                  in_clear,
  output logic                  ovf
`endif
);
  import vedic_pkg::*;

  localparam int unsigned SHIFT_W = $clog2(2 * LANE_W + 1);

  state_e             state_q, state_d;
  step_t              step_q;
  logic [IN_W-1:0]    a_q, b_q;
  logic [RES_W-1:0]   acc_q, out_prod_q;
  logic [RES_W-1:0]   acc_init;
  logic [SHIFT_W-1:0] pp_shift;
  logic [RES_W-1:0]   pp_ext;
  logic [RES_W:0]     sum;
  logic               accept;
  logic               last_pp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StMul;
      StMul:  if (last_pp) state_d = StDone;
      StDone: begin
        if (accept) begin
          state_d = StMul;
        end else if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    busy      = (state_q == StMul);
    out_valid = (state_q == StDone);
  end

  assign accept  = in_valid && in_ready;
  assign last_pp = busy && (step_q == LAST_STEP);

  vedic_pp_sel #(
    .IN_W    (IN_W),
    .LANE_W  (LANE_W),
    .SHIFT_W (SHIFT_W)
  ) u_pp_sel (
    .en    (busy),
    .step  (step_q),
    .a     (a_q),
    .b     (b_q),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .shift (pp_shift)
  );

  assign pp_ext = {{(RES_W - 2 * LANE_W){1'b0}}, mul_p} << pp_shift;
  assign sum    = {1'b0, acc_q} + {1'b0, pp_ext};

`ifdef VEDIC_SEQ_MAC_EN
  logic ovf_q;

  assign acc_init = in_clear ? '0 : out_prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept && in_clear) begin
      ovf_q <= 1'b0;
    end else if (busy && sum[RES_W]) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_carry;

  assign acc_init     = '0;
  assign unused_carry = sum[RES_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      out_prod_q <= '0;
    end else if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      step_q <= '0;
      acc_q  <= acc_init;
    end else if (busy) begin
      acc_q  <= sum[RES_W-1:0];
      step_q <= step_q + 2'd1;
      if (last_pp) begin
        out_prod_q <= sum[RES_W-1:0];
      end
    end
  end

  assign out_prod = out_prod_q;

endmodule

// File: tb/tb_vedic_8x8_seq.sv
// Directed bench for vedic_8x8_seq with a behavioural 4x4 core; MAC checks when VEDIC_SEQ_MAC_EN is set.
module tb_vedic_8x8_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_prod;
  logic        busy;
  logic        in_clear = 1'b1;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational 4x4 core
  assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

`ifndef VEDIC_SEQ_MAC_EN
  assign ovf = 1'b0;
`endif

  vedic_8x8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
`ifdef VEDIC_SEQ_MAC_EN
    ,
    .in_clear  (in_clear),
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lane_exp(input logic [7:0] a, input logic [7:0] b, input int s);
    case (s)
      0:       return {a[3:0], b[3:0]};
      1:       return {a[7:4], b[3:0]};
      2:       return {a[3:0], b[7:4]};
      default: return {a[7:4], b[7:4]};
    endcase
  endfunction

  // Called at a negedge with the DUT ready; the next posedge is the accept edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic clr);
    in_a     = a;
    in_b     = b;
    in_clear = clr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = a ^ 8'h5A;
    in_clear = ~clr;
  endtask

  // Returns at the first negedge where out_valid is high (or after a bounded wait).
  task automatic wait_result(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                             input string name);
    int cyc    = 0;
    int busy_n = 0;
    int wait_n = 0;
    bit got    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      if (cyc < 4) check({name, " lanes"}, {24'h0, mul_a, mul_b}, {24'h0, lane_exp(a, b, cyc)});
      busy_n += int'(busy);
      wait_n += int'(!in_ready);
      cyc++;
    end
    if (!got) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check({name, " latency"}, cyc, 4);
    check({name, " busy cycles"}, busy_n, 4);
    check({name, " in_ready low cycles"}, wait_n, 4);
    check({name, " out_prod"}, {16'h0, out_prod}, {16'h0, exp});
    check({name, " lanes idle in done"}, {24'h0, mul_a, mul_b}, 32'h0);
    check({name, " in_ready in done"}, {31'h0, in_ready}, 32'h0);
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    #1;
    check({name, " in_ready on drain"}, {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, " out_valid after drain"}, {31'h0, out_valid}, 32'h0);
    check({name, " in_ready after drain"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h0A, 8'h0B, 16'h006E};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h00, 8'hFF, 16'h0000};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{8'h55, 8'hAA, 16'h3872};
    vecs[7] = '{8'hC3, 8'h3C, 16'h2DB4};
    vecs[8] = '{8'hAB, 8'hCD, 16'h88EF};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", {31'h0, in_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset out_prod", {16'h0, out_prod}, 32'h0);
    check("reset lanes", {24'h0, mul_a, mul_b}, 32'h0);
    check("reset ovf", {31'h0, ovf}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b1);
      wait_result(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // Consumer stalls for three cycles: result must hold and input must stay blocked
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_result(8'hFF, 8'hFF, 16'hFE01, "stall");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall out_valid", {31'h0, out_valid}, 32'h1);
      check("stall out_prod", {16'h0, out_prod}, 32'h0000FE01);
      check("stall in_ready", {31'h0, in_ready}, 32'h0);
    end
    drain("stall");

    // Drain and accept on the same edge
    start_op(8'h0A, 8'h0B, 1'b1);
    wait_result(8'h0A, 8'h0B, 16'h006E, "b2b first");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h80;
    in_b      = 8'h02;
    in_clear  = 1'b1;
    #1;
    check("b2b in_ready on drain", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 8'hEE;
    in_b      = 8'h77;
    wait_result(8'h80, 8'h02, 16'h0100, "b2b second");
    drain("b2b second");

    // Reset during step 2 discards the operation
    start_op(8'h55, 8'hAA, 1'b1);
    repeat (3) @(negedge clk);
    check("midrst busy before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst in_ready", {31'h0, in_ready}, 32'h1);
    check("midrst busy", {31'h0, busy}, 32'h0);
    check("midrst out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst out_prod", {16'h0, out_prod}, 32'h0);
    check("midrst lanes", {24'h0, mul_a, mul_b}, 32'h0);
    start_op(8'h03, 8'h05, 1'b1);
    wait_result(8'h03, 8'h05, 16'h000F, "after rst");
    drain("after rst");

`ifdef VEDIC_SEQ_MAC_EN
    start_op(8'h10, 8'h10, 1'b1);
    wait_result(8'h10, 8'h10, 16'h0100, "mac clr");
    check("mac clr ovf", {31'h0, ovf}, 32'h0);
    drain("mac clr");
    start_op(8'h10, 8'h10, 1'b0);
    wait_result(8'h10, 8'h10, 16'h0200, "mac acc");
    check("mac acc ovf", {31'h0, ovf}, 32'h0);
    drain("mac acc");
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_result(8'hFF, 8'hFF, 16'hFE01, "mac ff clr");
    check("mac ff clr ovf", {31'h0, ovf}, 32'h0);
    drain("mac ff clr");
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_result(8'hFF, 8'hFF, 16'hFC02, "mac ff acc");
    check("mac ff acc ovf", {31'h0, ovf}, 32'h1);
    drain("mac ff acc");
    check("mac ovf sticky", {31'h0, ovf}, 32'h1);
    start_op(8'h01, 8'h01, 1'b1);
    wait_result(8'h01, 8'h01, 16'h0001, "mac reclr");
    check("mac reclr ovf", {31'h0, ovf}, 32'h0);
    drain("mac reclr");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
